// File: rtl/camera_patrol_ctrl_if.sv
// camera_patrol_ctrl_if
// Groups the camera-facing signals of the patrol controller.
//   Inputs to the controller: enable, camX, vision_startX/endX/startY/endY,
//     playerX, playerY, playerS, alarm_ack.
//   Outputs from the controller: direction_cam (00 left, 01 right, 11 stop),
//     alarm, in_view, state.
// modport master : the controller (drives direction_cam and status).
// modport slave  : the camera / game side (drives position, window, player).
interface camera_patrol_ctrl_if;
  logic       enable;
  logic [9:0] camX;
  logic [9:0] vision_startX;
  logic [9:0] vision_endX;
  logic [9:0] vision_startY;
  logic [9:0] vision_endY;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic [9:0] playerS;
  logic       alarm_ack;
  logic [1:0] direction_cam;
  logic       alarm;
  logic       in_view;
  logic [2:0] state;

  modport master (
    input  enable, camX, vision_startX, vision_endX, vision_startY, vision_endY,
    input  playerX, playerY, playerS, alarm_ack,
    output direction_cam, alarm, in_view, state
  );

  modport slave (
    output enable, camX, vision_startX, vision_endX, vision_startY, vision_endY,
    output playerX, playerY, playerS, alarm_ack,
    input  direction_cam, alarm, in_view, state
  );
endinterface

// File: rtl/camera_patrol_ctrl.sv
// camera_patrol_ctrl
// Sweeps a security camera between PATROL_X_MIN and PATROL_X_MAX, dwelling
// DWELL_FRAMES at each end, and raises alarm after DETECT_FRAMES consecutive
// frames with the player box inside the vision window. ALERT lasts at least
// ALARM_HOLD frames and is left only on alarm_ack.
// Ports:
//   frame_clk : frame-rate clock (only clock)
//   Reset_n   : asynchronous active-low reset
//   cam       : camera_patrol_ctrl_if.master (inputs: enable, camX, vision
//               window, player box, alarm_ack; outputs: direction_cam, alarm,
//               in_view, state -- all registered)
// Optional feature macro: CAM_PATROL_TIMEOUT_EN -- ends a sweep leg after
// SWEEP_TIMEOUT frames even if the camX limit is never reached.
module camera_patrol_ctrl #(
  parameter int PATROL_X_MIN  = 40,
  parameter int PATROL_X_MAX  = 600,
  parameter int DWELL_FRAMES  = 60,
  parameter int DETECT_FRAMES = 8,
  parameter int ALARM_HOLD    = 120,
  parameter int SWEEP_TIMEOUT = 250
) (
  input logic frame_clk,
  input logic Reset_n,
  camera_patrol_ctrl_if.master cam
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP_R = 3'd1,
    ST_DWELL_R = 3'd2,
    ST_SWEEP_L = 3'd3,
    ST_DWELL_L = 3'd4,
    ST_ALERT   = 3'd5
  } state_t;

  localparam logic [9:0] X_MIN       = 10'(PATROL_X_MIN);
  localparam logic [9:0] X_MAX       = 10'(PATROL_X_MAX);
  localparam logic [7:0] DWELL_LAST  = 8'(DWELL_FRAMES - 1);
  localparam logic [7:0] DETECT_LAST = 8'(DETECT_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(ALARM_HOLD - 1);

  // Reject out-of-range configurations at elaboration.
  if (DWELL_FRAMES < 1 || DWELL_FRAMES > 255 || DETECT_FRAMES < 1 || DETECT_FRAMES > 255 ||
      ALARM_HOLD < 1 || ALARM_HOLD > 255 || SWEEP_TIMEOUT < 1 || SWEEP_TIMEOUT > 255) begin : g_bad_cfg
    $error("camera_patrol_ctrl: frame-count parameter out of range 1..255");
  end

  // Low box edge, clamped at 0 when the half-size exceeds the centre.
  function automatic logic [9:0] edge_lo(input logic [9:0] c, input logic [9:0] s);
    logic [10:0] d;
    d = {1'b0, c} - {1'b0, s};
    edge_lo = d[10] ? 10'd0 : d[9:0];
  endfunction

  // High box edge, clamped at 1023.
  function automatic logic [9:0] edge_hi(input logic [9:0] c, input logic [9:0] s);
    logic [10:0] d;
    d = {1'b0, c} + {1'b0, s};
    edge_hi = d[10] ? 10'd1023 : d[9:0];
  endfunction

  // Command encoding for each state; only the sweeps move the camera.
  function automatic logic [1:0] dir_of(input state_t st);
    case (st)
      ST_SWEEP_R: dir_of = 2'b01;
      ST_SWEEP_L: dir_of = 2'b00;
      default:    dir_of = 2'b11;
    endcase
  endfunction

  state_t     state_r, state_nx_s, patrol_nx_s;
  logic [1:0] dir_r;
  logic       alarm_r, in_view_r, last_right_r;
  logic [7:0] det_cnt_r, det_cnt_nx_s, dwell_cnt_r, hold_cnt_r;
  logic       overlap_s, patrol_s, detect_s, done_r_s, done_l_s;
`ifdef CAM_PATROL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(SWEEP_TIMEOUT - 1);
  logic [7:0] leg_cnt_r;
`endif

  // Player box vs. vision window, inclusive on both axes.
  always_comb begin
    overlap_s = (edge_lo(cam.playerX, cam.playerS) <= cam.vision_endX) &&
                (edge_hi(cam.playerX, cam.playerS) >= cam.vision_startX) &&
                (edge_lo(cam.playerY, cam.playerS) <= cam.vision_endY) &&
                (edge_hi(cam.playerY, cam.playerS) >= cam.vision_startY);
  end

  // Sweep-leg completion: limit reached (or leg timed out when enabled).
  always_comb begin
`ifdef CAM_PATROL_TIMEOUT_EN
    done_r_s = (cam.camX >= X_MAX) || (leg_cnt_r == TIMEOUT_LAST);
    done_l_s = (cam.camX <= X_MIN) || (leg_cnt_r == TIMEOUT_LAST);
`else
    done_r_s = (cam.camX >= X_MAX);
    done_l_s = (cam.camX <= X_MIN);
`endif
  end

  // Detection qualifier: the increment that reaches DETECT_FRAMES triggers ALERT.
  always_comb begin
    patrol_s = (state_r == ST_SWEEP_R) || (state_r == ST_DWELL_R) ||
               (state_r == ST_SWEEP_L) || (state_r == ST_DWELL_L);
    detect_s = patrol_s && in_view_r && (det_cnt_r == DETECT_LAST);
  end

  // Next-state logic: patrol sequencing, then disable and detection overrides.
  always_comb begin
    patrol_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cam.enable) patrol_nx_s = last_right_r ? ST_SWEEP_R : ST_SWEEP_L;
        else            patrol_nx_s = ST_IDLE;
      end
      ST_SWEEP_R: patrol_nx_s = done_r_s ? ST_DWELL_R : ST_SWEEP_R;
      ST_DWELL_R: patrol_nx_s = (dwell_cnt_r == DWELL_LAST) ? ST_SWEEP_L : ST_DWELL_R;
      ST_SWEEP_L: patrol_nx_s = done_l_s ? ST_DWELL_L : ST_SWEEP_L;
      ST_DWELL_L: patrol_nx_s = (dwell_cnt_r == DWELL_LAST) ? ST_SWEEP_R : ST_DWELL_L;
      ST_ALERT: begin
        if ((hold_cnt_r >= HOLD_LAST) && cam.alarm_ack) patrol_nx_s = ST_IDLE;
        else                                            patrol_nx_s = ST_ALERT;
      end
      default: patrol_nx_s = ST_IDLE;
    endcase
    state_nx_s = patrol_nx_s;
    if (state_r == ST_ALERT) state_nx_s = patrol_nx_s;
    else if (!cam.enable)    state_nx_s = ST_IDLE;
    else if (detect_s)       state_nx_s = ST_ALERT;
    else                     state_nx_s = patrol_nx_s;
  end

  // Consecutive-sighting counter next value.
  always_comb begin
    det_cnt_nx_s = det_cnt_r;
    if ((state_r != ST_ALERT) && !cam.enable) det_cnt_nx_s = 8'd0;
    else if (detect_s)                        det_cnt_nx_s = 8'd0;
    else if (!in_view_r)                      det_cnt_nx_s = 8'd0;
    else if (patrol_s && (det_cnt_r != 8'd255)) det_cnt_nx_s = det_cnt_r + 8'd1;
    else                                      det_cnt_nx_s = det_cnt_r;
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      dir_r     <= 2'b11;
      alarm_r   <= 1'b0;
      in_view_r <= 1'b0;
      det_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_nx_s;
      dir_r     <= dir_of(state_nx_s);
      alarm_r   <= (state_nx_s == ST_ALERT);
      in_view_r <= overlap_s;
      det_cnt_r <= det_cnt_nx_s;
    end
  end

  // Dwell and alert-hold counters; both restart whenever their state is entered.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dwell_cnt_r <= 8'd0;
      hold_cnt_r  <= 8'd0;
    end else begin
      if ((state_nx_s == state_r) && ((state_r == ST_DWELL_R) || (state_r == ST_DWELL_L)))
        dwell_cnt_r <= dwell_cnt_r + 8'd1;
      else
        dwell_cnt_r <= 8'd0;
      if ((state_r == ST_ALERT) && (state_nx_s == ST_ALERT))
        hold_cnt_r <= (hold_cnt_r == 8'd255) ? 8'd255 : hold_cnt_r + 8'd1;
      else
        hold_cnt_r <= 8'd0;
    end
  end

  // Remembers the sweep direction chosen at the last dwell expiry.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)                                              last_right_r <= 1'b1;
    else if ((state_r == ST_DWELL_R) && (state_nx_s == ST_SWEEP_L)) last_right_r <= 1'b0;
    else if ((state_r == ST_DWELL_L) && (state_nx_s == ST_SWEEP_R)) last_right_r <= 1'b1;
    else                                                       last_right_r <= last_right_r;
  end

`ifdef CAM_PATROL_TIMEOUT_EN
  // Frames spent in the current sweep leg; cleared on any state change.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)
      leg_cnt_r <= 8'd0;
    else if ((state_nx_s == state_r) && ((state_r == ST_SWEEP_R) || (state_r == ST_SWEEP_L)))
      leg_cnt_r <= leg_cnt_r + 8'd1;
    else
      leg_cnt_r <= 8'd0;
  end
`endif

  assign cam.direction_cam = dir_r;
  assign cam.alarm         = alarm_r;
  assign cam.in_view       = in_view_r;
  assign cam.state         = state_r;

endmodule
